// File: rtl/id_hazard_unit_pkg.sv
// Shared constants and width helpers for the decode-stage operand hazard unit.
package id_hazard_unit_pkg;

  localparam int FWD_SEL_RF       = 0;
  localparam int MC_CNT_WIDTH_DEF = 6;

  // Forward-select encoding: 0 = register file, k+1 = stage k.
  function automatic int sel_width(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

  // Record "ready stage" field holds a stage index in [0, num_stages-1].
  function automatic int rdy_width(input int num_stages);
    return (num_stages > 1) ? $clog2(num_stages) : 1;
  endfunction

endpackage

// File: rtl/id_hazard_unit_fwd_port_mux.sv
// Priority match over the in-flight records plus operand mux for one decode read port.
module fwd_port_mux
  import id_hazard_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_STAGES     = 3,
  parameter int RDY_W          = 2,
  parameter int SEL_W          = 2
) (
  input  logic [NUM_STAGES-1:0]                stg_valid,
  input  logic [NUM_STAGES*REG_ADDR_WIDTH-1:0] stg_waddr,
  input  logic [NUM_STAGES*RDY_W-1:0]          stg_rdy,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0]     stg_data,
  input  logic [REG_ADDR_WIDTH-1:0]            raddr,
  input  logic                                 ruse,
  input  logic [DATA_WIDTH-1:0]                rdata,
  output logic [DATA_WIDTH-1:0]                op,
  output logic [SEL_W-1:0]                     sel,
  output logic                                 hazard
);

  // Walk oldest to youngest so the lowest-index match has the final word.
  always_comb begin
    op     = rdata;
    sel    = SEL_W'(FWD_SEL_RF);
    hazard = 1'b0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (stg_valid[k] && (stg_waddr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == raddr) &&
          (raddr != '0) && ruse) begin
        if (RDY_W'(k) >= stg_rdy[k*RDY_W +: RDY_W]) begin
          op     = stg_data[k*DATA_WIDTH +: DATA_WIDTH];
          sel    = SEL_W'(k + 1);
          hazard = 1'b0;
        end else begin
          op     = rdata;
          sel    = SEL_W'(FWD_SEL_RF);
          hazard = 1'b1;
        end
      end else begin
        op     = op;
        sel    = sel;
        hazard = hazard;
      end
    end
  end

endmodule

// File: rtl/id_hazard_unit.sv
// Decode-stage operand hazard unit: shadow record pipeline, N-port forwarding,
// load-use stall and multi-cycle issue hold.
module id_hazard_unit
  import id_hazard_unit_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int NUM_RD_PORTS     = 2,
  parameter int NUM_STAGES       = 3,
  parameter int LOAD_READY_STAGE = 2,
  parameter int MC_CNT_WIDTH     = MC_CNT_WIDTH_DEF,
  localparam int SEL_W           = sel_width(NUM_STAGES)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   id_valid_i,
  input  logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0] id_raddr_i,
  input  logic [NUM_RD_PORTS-1:0]                id_ruse_i,
  input  logic [NUM_RD_PORTS*DATA_WIDTH-1:0]     id_rdata_i,
  input  logic                                   id_wr_i,
  input  logic [REG_ADDR_WIDTH-1:0]              id_waddr_i,
  input  logic                                   id_load_i,
  input  logic                                   id_mc_i,
  input  logic [MC_CNT_WIDTH-1:0]                id_mc_cycles_i,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0]       stg_data_i,
  input  logic                                   flush_i,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]     op_o,
  output logic [NUM_RD_PORTS*SEL_W-1:0]          fwd_sel_o,
  output logic                                   stall_o,
  output logic                                   busy_o,
  output logic                                   issue_o,
  output logic [NUM_STAGES-1:0]                  stg_valid_o
);

  localparam int RDY_W = rdy_width(NUM_STAGES);

  logic [NUM_STAGES-1:0]                valid_r;
  logic [NUM_STAGES*REG_ADDR_WIDTH-1:0] waddr_r;
  logic [NUM_STAGES*RDY_W-1:0]          rdy_r;
  logic [MC_CNT_WIDTH-1:0]              mc_cnt_r;
  logic [MC_CNT_WIDTH-1:0]              mc_cnt_nxt_s;
  logic [NUM_RD_PORTS-1:0]              hazard_s;
  logic                                 push_s;
  logic                                 shift_s;
  logic [RDY_W-1:0]                     new_rdy_s;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    fwd_port_mux #(
      .DATA_WIDTH    (DATA_WIDTH),
      .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
      .NUM_STAGES    (NUM_STAGES),
      .RDY_W         (RDY_W),
      .SEL_W         (SEL_W)
    ) u_mux (
      .stg_valid(valid_r),
      .stg_waddr(waddr_r),
      .stg_rdy  (rdy_r),
      .stg_data (stg_data_i),
      .raddr    (id_raddr_i[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
      .ruse     (id_ruse_i[p]),
      .rdata    (id_rdata_i[p*DATA_WIDTH +: DATA_WIDTH]),
      .op       (op_o[p*DATA_WIDTH +: DATA_WIDTH]),
      .sel      (fwd_sel_o[p*SEL_W +: SEL_W]),
      .hazard   (hazard_s[p])
    );
  end

  assign busy_o      = (mc_cnt_r != '0);
  assign stall_o     = id_valid_i & (|hazard_s);
  assign issue_o     = id_valid_i & ~stall_o & ~busy_o;
  assign stg_valid_o = valid_r;

  // Flush overrides the hold so older records keep draining.
  assign push_s    = issue_o & id_wr_i & (id_waddr_i != '0) & ~flush_i;
  assign shift_s   = ~busy_o | flush_i;
  assign new_rdy_s = id_load_i ? RDY_W'(LOAD_READY_STAGE) : RDY_W'(0);

  // Record pipeline: shift when not held, new record (or bubble) enters stage 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      waddr_r <= '0;
      rdy_r   <= '0;
    end else if (shift_s) begin
      for (int k = NUM_STAGES - 1; k >= 1; k--) begin
        valid_r[k]                                 <= valid_r[k-1];
        waddr_r[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] <= waddr_r[(k-1)*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        rdy_r[k*RDY_W +: RDY_W]                     <= rdy_r[(k-1)*RDY_W +: RDY_W];
      end
      valid_r[0]                <= push_s;
      waddr_r[0 +: REG_ADDR_WIDTH] <= id_waddr_i;
      rdy_r[0 +: RDY_W]         <= new_rdy_s;
    end
  end

  // Multi-cycle counter: load N-1 on issue, count down while busy, clear on flush.
  always_comb begin
    mc_cnt_nxt_s = mc_cnt_r;
    if (flush_i) begin
      mc_cnt_nxt_s = '0;
    end else if (busy_o) begin
      mc_cnt_nxt_s = mc_cnt_r - MC_CNT_WIDTH'(1);
    end else if (issue_o && id_mc_i && (id_mc_cycles_i > MC_CNT_WIDTH'(1))) begin
      mc_cnt_nxt_s = id_mc_cycles_i - MC_CNT_WIDTH'(1);
    end else begin
      mc_cnt_nxt_s = mc_cnt_r;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_cnt_r <= '0;
    end else begin
      mc_cnt_r <= mc_cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_id_hazard_unit.sv
// Directed self-checking bench for id_hazard_unit at default parameters.
module tb_id_hazard_unit;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NP = 2;
  localparam int NS = 3;
  localparam int MW = 6;
  localparam int SW = 2;

  logic            clk;
  logic            rst_n;
  logic            id_valid;
  logic [NP*AW-1:0] id_raddr;
  logic [NP-1:0]   id_ruse;
  logic [NP*DW-1:0] id_rdata;
  logic            id_wr;
  logic [AW-1:0]   id_waddr;
  logic            id_load;
  logic            id_mc;
  logic [MW-1:0]   id_mc_cycles;
  logic [NS*DW-1:0] stg_data;
  logic            flush;
  logic [NP*DW-1:0] op;
  logic [NP*SW-1:0] fwd_sel;
  logic            stall;
  logic            busy;
  logic            issue;
  logic [NS-1:0]   stg_valid;

  int total = 0;
  int bad   = 0;

  localparam logic [DW-1:0] D0 = 32'hDEADBEEF;
  localparam logic [DW-1:0] D1 = 32'h11111111;
  localparam logic [DW-1:0] D2 = 32'h22222222;
  localparam logic [DW-1:0] R0 = 32'hA0A0A0A0;
  localparam logic [DW-1:0] R1 = 32'hB1B1B1B1;

  id_hazard_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid_i    (id_valid),
    .id_raddr_i    (id_raddr),
    .id_ruse_i     (id_ruse),
    .id_rdata_i    (id_rdata),
    .id_wr_i       (id_wr),
    .id_waddr_i    (id_waddr),
    .id_load_i     (id_load),
    .id_mc_i       (id_mc),
    .id_mc_cycles_i(id_mc_cycles),
    .stg_data_i    (stg_data),
    .flush_i       (flush),
    .op_o          (op),
    .fwd_sel_o     (fwd_sel),
    .stall_o       (stall),
    .busy_o        (busy),
    .issue_o       (issue),
    .stg_valid_o   (stg_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    id_valid     = 1'b0;
    id_raddr     = '0;
    id_ruse      = '0;
    id_wr        = 1'b0;
    id_waddr     = '0;
    id_load      = 1'b0;
    id_mc        = 1'b0;
    id_mc_cycles = '0;
    flush        = 1'b0;
  endtask

  task automatic writer(input logic [AW-1:0] rd, input logic ld);
    idle();
    id_valid = 1'b1;
    id_wr    = 1'b1;
    id_waddr = rd;
    id_load  = ld;
  endtask

  task automatic reader(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [NP-1:0] use_mask);
    idle();
    id_valid = 1'b1;
    id_raddr = {a1, a0};
    id_ruse  = use_mask;
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  initial begin
    stg_data = {D2, D1, D0};
    id_rdata = {R1, R0};
    idle();
    rst_n = 1'b0;

    // Reset state with a valid decode instruction present
    reader(5'd5, 5'd7, 2'b11);
    #3;
    chk("rst_stall", stall, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_stg_valid", stg_valid, 3'b000);
    chk("rst_op", op, {R1, R0});
    chk("rst_sel", fwd_sel, 4'h0);
    chk("rst_issue", issue, 1'b1);
    #9;
    rst_n = 1'b1;
    idle();
    step();

    // ALU chain: x5 producer then consumer forwards from stage 0
    writer(5'd5, 1'b0);
    #1;
    chk("alu_issue", issue, 1'b1);
    step();
    reader(5'd5, 5'd0, 2'b11);
    #1;
    chk("alu_stg_valid", stg_valid, 3'b001);
    chk("alu_sel0", fwd_sel[1:0], 2'd1);
    chk("alu_op0", op[31:0], D0);
    chk("alu_sel1_x0", fwd_sel[3:2], 2'd0);
    chk("alu_op1_rf", op[63:32], R1);
    chk("alu_stall", stall, 1'b0);
    step();
    drain();
    chk("drain_empty", stg_valid, 3'b000);

    // Load-use: two stall cycles then forward from stage 2
    writer(5'd7, 1'b1);
    step();
    reader(5'd0, 5'd7, 2'b10);
    #1;
    chk("lu_stall_1", stall, 1'b1);
    chk("lu_issue_1", issue, 1'b0);
    step();
    #1;
    chk("lu_stall_2", stall, 1'b1);
    chk("lu_stg_valid_2", stg_valid, 3'b010);
    step();
    #1;
    chk("lu_stall_3", stall, 1'b0);
    chk("lu_issue_3", issue, 1'b1);
    chk("lu_sel", fwd_sel, 4'hC);
    chk("lu_op1", op[63:32], D2);
    step();
    drain();

    // Priority: x3 in stages 0 and 2, x0 writer in between never records
    writer(5'd3, 1'b0);
    step();
    writer(5'd0, 1'b0);
    step();
    writer(5'd3, 1'b0);
    step();
    reader(5'd3, 5'd0, 2'b11);
    #1;
    chk("prio_stg_valid", stg_valid, 3'b101);
    chk("prio_sel", fwd_sel, 4'h1);
    chk("prio_op0", op[31:0], D0);
    chk("prio_op1_x0", op[63:32], R1);
    step();
    drain();

    // Younger ALU x4 shadows an older unready load x4: no stall
    writer(5'd4, 1'b1);
    step();
    writer(5'd4, 1'b0);
    step();
    reader(5'd4, 5'd0, 2'b01);
    #1;
    chk("young_stall", stall, 1'b0);
    chk("young_sel", fwd_sel, 4'h1);
    step();
    drain();

    // Multi-cycle op of 4 cycles holds issue for 3 cycles
    writer(5'd9, 1'b0);
    id_mc        = 1'b1;
    id_mc_cycles = 6'd4;
    #1;
    chk("mc_issue", issue, 1'b1);
    chk("mc_busy_0", busy, 1'b0);
    step();
    reader(5'd9, 5'd0, 2'b01);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mc_busy", busy, 1'b1);
      chk("mc_issue_hold", issue, 1'b0);
      chk("mc_frozen", stg_valid, 3'b001);
      step();
    end
    #1;
    chk("mc_release_busy", busy, 1'b0);
    chk("mc_release_issue", issue, 1'b1);
    chk("mc_release_sel", fwd_sel[1:0], 2'd1);
    chk("mc_release_op", op[31:0], D0);
    step();
    drain();

    // mc_cycles of 1 does not hold
    writer(5'd9, 1'b0);
    id_mc        = 1'b1;
    id_mc_cycles = 6'd1;
    step();
    idle();
    #1;
    chk("mc1_busy", busy, 1'b0);
    drain();

    // Flush on the mc issue cycle: no hold and no stage-0 record
    writer(5'd9, 1'b0);
    id_mc        = 1'b1;
    id_mc_cycles = 6'd4;
    flush        = 1'b1;
    step();
    idle();
    #1;
    chk("fl_issue_busy", busy, 1'b0);
    chk("fl_issue_stg0", stg_valid[0], 1'b0);
    drain();

    // Flush while busy: hold drops next cycle and older records shift
    writer(5'd9, 1'b0);
    id_mc        = 1'b1;
    id_mc_cycles = 6'd5;
    step();
    idle();
    flush = 1'b1;
    #1;
    chk("fl_busy_before", busy, 1'b1);
    step();
    idle();
    #1;
    chk("fl_busy_after", busy, 1'b0);
    chk("fl_busy_stg", stg_valid, 3'b010);
    drain();

    // Asynchronous reset mid-operation clears a pending load hazard
    writer(5'd7, 1'b1);
    step();
    reader(5'd7, 5'd0, 2'b01);
    #1;
    chk("ar_stall_pre", stall, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("ar_stg_valid", stg_valid, 3'b000);
    chk("ar_stall", stall, 1'b0);
    chk("ar_op", op[31:0], R0);
    rst_n = 1'b1;
    step();
    #1;
    chk("ar_stall_post", stall, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_hazard_unit.md
# id_hazard_unit

Parametrised operand-hazard unit for the decode stage. It tracks in-flight register writers in a shadow record pipeline and forwards the youngest ready result to each decode read port. When the youngest producer's data is not yet available it stalls with a load-use bubble, and it holds issue for the duration of multi-cycle operations. It sits between the register file outputs and the decode/execute pipeline register, and generalises fixed two-port, three-source forwarding to N read ports, S stages and a configurable load latency.

## Interface
- DATA_WIDTH, 32, operand width
- REG_ADDR_WIDTH, 5, register address width
- NUM_RD_PORTS, 2, decode read ports
- NUM_STAGES, 3, tracked stages after decode (0 = EXE)
- LOAD_READY_STAGE, 2, first stage index at which load data is forwardable; must be < NUM_STAGES
- MC_CNT_WIDTH, 6, multi-cycle latency counter width
- SEL_W is derived as $clog2(NUM_STAGES+1)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  decode holds a valid instruction
- id_raddr_i  in  NUM_RD_PORTS*REG_ADDR_WIDTH  source addresses, port p at [p*RAW +: RAW]
- id_ruse_i  in  NUM_RD_PORTS  port actually consumes its operand
- id_rdata_i  in  NUM_RD_PORTS*DATA_WIDTH  register file read data
- id_wr_i  in  1  instruction writes rd
- id_waddr_i  in  REG_ADDR_WIDTH  rd
- id_load_i  in  1  instruction is a load
- id_mc_i  in  1  instruction is multi-cycle
- id_mc_cycles_i  in  MC_CNT_WIDTH  multi-cycle EXE latency
- stg_data_i  in  NUM_STAGES*DATA_WIDTH  result carried by stage k
- flush_i  in  1  kill instruction entering stage 0
- op_o  out  NUM_RD_PORTS*DATA_WIDTH  forwarded operands (combinational)
- fwd_sel_o  out  NUM_RD_PORTS*SEL_W  0 = register file, k+1 = stage k
- stall_o  out  1  load-use stall
- busy_o  out  1  multi-cycle hold
- issue_o  out  1  id_valid_i & !stall_o & !busy_o
- stg_valid_o  out  NUM_STAGES  record-valid per stage (debug/verification)

## Operation
- Record per stage: {valid, waddr, rdy}. rdy is LOAD_READY_STAGE for loads, otherwise 0.
- Push: on issue_o with id_wr_i and id_waddr_i != 0, stage 0 gets {1, id_waddr_i, rdy}. Any other non-busy cycle pushes an invalid record (bubble).
- Shift: when busy_o=0, records shift from stage k to k+1 every cycle. The record leaving the last stage is dropped.
- Match rule: port p matches stage k when valid[k] & waddr[k]==raddr[p] & raddr[p]!=0 & id_ruse_i[p].
- Forwarding uses the lowest-index matching stage k*. If k* >= rdy[k*], then op = stg_data_i[k*] and sel = k*+1. With no match, op = id_rdata_i[p] and sel = 0.
- Stall: stall_o=1 when id_valid_i is high and some port has k* < rdy[k*]. Only the youngest match decides the stall; older matches are ignored.
- Multi-cycle: an issue with id_mc_i=1 and id_mc_cycles_i > 1 loads the counter with id_mc_cycles_i-1.
  - busy_o = (counter != 0).
  - While busy, the counter decrements and all records are frozen.
  - id_mc_cycles_i of 0 or 1 does not hold.
- Flush: flush_i forces the next stage-0 record invalid and clears the counter. It overrides both issue and busy. Older stages still shift.
- Reset: all records invalid and counter 0. Therefore stall_o=0, busy_o=0, fwd_sel_o=0, stg_valid_o=0, op_o=id_rdata_i, and issue_o=id_valid_i.

## Timing
- Forwarding, stall and issue are combinational from the record state plus the current decode inputs. Records and counter are updated on the rising clk edge.
- Load-use: a load issued in cycle t is in stage 0 at t+1. A dependent instruction in decode stalls through t+1 and t+2 (LOAD_READY_STAGE cycles), then forwards from stage 2 at t+3.
- ALU dependency: a producer issued at t forwards from stage 0 at t+1 with zero stall.
- A multi-cycle op of N cycles asserts busy_o for N-1 cycles starting the cycle after issue.
- Reset mid-operation: records clear immediately and asynchronously. No stall persists.

## Structure
- Shared package holds SEL encoding constants (FWD_SEL_RF=0), the record struct/field widths, and the MC_CNT_WIDTH default.
- One natural sub-module, `fwd_port_mux`: a priority match plus data mux for a single port, instantiated NUM_RD_PORTS times via generate.

## Test plan
- Reset: apply rst_n=0 with id_valid_i=1 -> stall_o=0, busy_o=0, stg_valid_o=000, op_o equals id_rdata_i.
- ALU chain: issue x5 writer, then read x5 with stg_data_i[0]=0xDEADBEEF -> fwd_sel=1, op=0xDEADBEEF, no stall.
- Load-use: load x7, then a dependent reading x7 -> stall_o high for exactly 2 cycles, then sel=3, op=stg_data_i[2].
- Priority: x3 valid in stages 0 and 2 (both ALU) -> sel=1 with stage-0 data. Reading x0 while an x0 writer is in flight -> sel=0.
- Multi-cycle: issue mc with cycles=4 -> busy_o high 3 cycles, issue_o=0, stg_valid_o frozen. Dependent forwards from stage 0 on release.
- Flush: flush_i during mc issue -> busy_o never rises and stg_valid_o[0]=0 next cycle. flush_i during busy -> busy_o drops the next cycle.
